// File: rtl/mult_share_arbiter.sv
// Shares one pipelined W x W multiplier among NREQ requesters with a one-hot tag pipe for returns.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mult_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int LAT  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   input  logic [2*W-1:0]      mul_p,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [2*W-1:0]      rsp_data,
   output logic                busy
);

   localparam int PW = $clog2(NREQ);

   logic [W-1:0]              opa [NREQ];
   logic [W-1:0]              opb [NREQ];
   logic [NREQ-1:0]           grant;
   logic [PW-1:0]             win_idx;
   logic [W-1:0]              mul_a_reg;
   logic [W-1:0]              mul_b_reg;
   logic [LAT:0][NREQ-1:0]    tag_reg;
   logic [NREQ-1:0]           rsp_valid_reg;
   logic [2*W-1:0]            rsp_data_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign opa[gi] = req_a[gi*W +: W];
         assign opb[gi] = req_b[gi*W +: W];
      end
   endgenerate

`ifdef MULT_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last (winning) write.
   always_comb begin
      grant   = '0;
      win_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            grant   = '0;
            grant[k] = 1'b1;
            win_idx = PW'(k);
         end
      end
   end
`else
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_next;

   // Scan offsets from the pointer downwards so the nearest valid requester wins.
   always_comb begin
      int j;
      grant   = '0;
      win_idx = '0;
      j       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr_reg) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req_valid[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            win_idx  = PW'(j);
         end
      end
   end

   assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg <= '0;
      end else if (|grant) begin
         ptr_reg <= ptr_next;
      end
   end
`endif

   // Grant is suppressed while reset is held so no accept can be seen.
   assign req_ready = grant & {NREQ{rst}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_a_reg <= '0;
         mul_b_reg <= '0;
      end else if (|grant) begin
         mul_a_reg <= opa[win_idx];
         mul_b_reg <= opb[win_idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_reg <= '0;
      end else begin
         tag_reg <= {tag_reg[LAT-1:0], grant};
      end
   end

   // Product is captured only when a tagged op reaches the end; otherwise the data holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_valid_reg <= tag_reg[LAT];
         if (|tag_reg[LAT]) begin
            rsp_data_reg <= mul_p;
         end
      end
   end

   assign mul_a     = mul_a_reg;
   assign mul_b     = mul_b_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign busy      = |tag_reg;

endmodule
